turf_cmd_rx: RTL
================

// Module: turf_cmd_rx
// PURPOSE
//  Serial receiver/decoder for the TURF CMD line (after its LVDS buffer), running on clk33.
//  Frames digitize/clear/reset commands and holds per-buffer digitize requests until the LAB readout reports done.
//  Feeds the register/readout controller's digitize and clear inputs.
// PARAMETERS
//  NBUF        4   number of LAB hold buffers; buffer field is 2 bits, so NBUF<=4
//  SYNC_STAGES 2   flip-flop stages synchronising cmd_i into clk_i
//  ERR_W       8   width of the saturating error counter
// PORTS
//  clk_i          in   1      33 MHz system clock
//  rst_n_i        in   1      asynchronous active-low reset
//  cmd_i          in   1      raw CMD serial bit, 1 bit per clk_i, idle low
//  done_i         in   NBUF   1-cycle pulse: buffer b digitize/readout finished
//  digitize_o     out  NBUF   level: digitize pending for buffer b
//  clear_o        out  NBUF   1-cycle pulse: discard buffer b
//  rst_req_o      out  1      1-cycle pulse: TURF global reset command
//  evt_tag_o      out  4      tag of last accepted digitize command
//  evt_valid_o    out  1      1-cycle pulse when evt_tag_o updates
//  err_cnt_o      out  ERR_W  saturating count of frame/parity/overflow errors
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; synchroniser flops 0. All logic uses async-assert reset; cmd path flops included.
//  Frame (MSB first, 1 bit/cycle, post-sync): start=1, cmd[1:0], buf[1:0], tag[3:0], [parity], stop=0.
//  cmd: 00 no-op, 01 digitize, 10 clear, 11 global reset.
//  FSM: IDLE -(bit=1)-> SHIFT (8 bits, 3-bit counter 0..7) -> PARITY (if enabled) -> STOP -> IDLE.
//   STOP samples stop bit; decision made there. At STOP: if bit=0 and parity OK, the frame is accepted.
//   Otherwise the frame is a framing/parity error: err_cnt_o increments, the frame is discarded, and the FSM returns to IDLE.
//   No back-to-back restriction: IDLE may see a new start bit the cycle after STOP.
//  Actions register the cycle after STOP. Latency from start bit at cmd_i to output = SYNC_STAGES+11 cycles with parity, +10 without.
//  digitize (01):
//   If pend[buf]==0, set pend[buf], latch tag into evt_tag_o, pulse evt_valid_o.
//   If pend[buf]==1 already, this is an overflow: err_cnt_o++, pend and evt_tag_o are unchanged, and evt_valid_o does not pulse.
//  clear (10): pend[buf]<=0; clear_o[buf] pulses 1 cycle, whether or not the buffer was pending.
//  reset (11): pend<=0 for all buffers; rst_req_o pulses; err_cnt_o is NOT cleared (only rst_n_i clears it).
//  no-op (00): no effect beyond frame checks.
//  Buffer field >= NBUF: frame counts as an error (err_cnt_o++), no action.
//  digitize_o = pend. done_i[b] clears pend[b] the next cycle.
//  Simultaneous done_i[b] and an accepted digitize for the same b: the set wins, pend[b] stays 1, and it is not an overflow.
//  Simultaneous done_i[b] and clear/reset: result is 0.
//  done_i on a non-pending buffer: ignored.
//  err_cnt_o saturates at 2^ERR_W-1.
//  Multiple error causes in one frame count as one increment.
//  rst_n_i assertion mid-frame: immediate return to IDLE, partial frame lost.
// CONFIGURATION
//  TURF_CMD_PARITY_EN defined:
//   Frame is 11 bits and includes the PARITY state.
//   Odd parity over the 8 payload bits is required; a mismatch counts as an error.
//  TURF_CMD_PARITY_EN undefined:
//   Frame is 10 bits; the PARITY state is not built.
//   The only frame error is a bad stop bit.
// TESTING
//  1. Send digitize buf=2 tag=0x5 (parity ok) -> digitize_o=4'b0100, evt_tag_o=5, evt_valid_o one pulse at start+SYNC_STAGES+11.
//  2. Repeat digitize buf=2 before done_i -> err_cnt_o=1, evt_tag_o stays 5; then done_i[2] pulse -> digitize_o=0.
//  3. Frame with stop bit=1, then a frame with wrong parity -> err_cnt_o increments twice, no output change.
//  4. clear buf=1 with pend[1]=1 in the same cycle done_i[1] -> clear_o=4'b0010 for 1 cycle, digitize_o[1]=0.
//  5. Pend buffers 0 and 3, send reset -> rst_req_o pulses, digitize_o=0, err_cnt_o unchanged.
//  6. Drop rst_n_i after the 4th frame bit, release, send valid digitize buf=0 -> accepted cleanly; err_cnt_o=0.
//  7. Force 300 bad frames with ERR_W=8 -> err_cnt_o holds 255.
//  8. Run the bench both with and without TURF_CMD_PARITY_EN.

Source files
------------

// File: rtl/turf_cmd_rx.sv
// turf_cmd_rx: TURF CMD serial frame receiver and per-buffer digitize request holder.
// Latency: start bit at cmd_i to action outputs = SYNC_STAGES+11 cycles (parity) / +10 (no parity).
// Backpressure: none; the CMD line cannot be stalled, so errors are counted rather than stalled.
//
// Build option: define TURF_CMD_PARITY_EN to add an odd-parity bit after the payload
// (11-bit frame). Default build (undefined) uses a 10-bit frame with stop-bit checking only.
//
// Ports:
//   clk_i        33 MHz system clock
//   rst_n_i      asynchronous active-low reset
//   cmd_i        raw CMD serial bit (idle low), one bit per clk_i, MSB first
//   done_i       per-buffer 1-cycle pulse: readout finished, drop the pending request
//   digitize_o   per-buffer level: digitize pending
//   clear_o      per-buffer 1-cycle pulse: discard buffer
//   rst_req_o    1-cycle pulse: global reset command received
//   evt_tag_o    tag of last accepted digitize command
//   evt_valid_o  1-cycle pulse when evt_tag_o updates
//   err_cnt_o    saturating count of frame/parity/buffer-range/overflow errors
//
// Frame layout after synchronisation:
//   start(1) cmd[1:0] buf[1:0] tag[3:0] [parity] stop(0)
// cmd: 00 no-op, 01 digitize, 10 clear, 11 global reset.

module turf_cmd_rx #(
  parameter int NBUF        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_i,
  input  logic [NBUF-1:0]  done_i,
  output logic [NBUF-1:0]  digitize_o,
  output logic [NBUF-1:0]  clear_o,
  output logic             rst_req_o,
  output logic [3:0]       evt_tag_o,
  output logic             evt_valid_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_DIG = 2'b01;
  localparam logic [1:0] CMD_CLR = 2'b10;
  localparam logic [1:0] CMD_RST = 2'b11;

`ifdef TURF_CMD_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd3
  } state_t;
`endif

  // ------------------------------------------------------------------
  // Input synchroniser
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_bit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= cmd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_bit = r_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------------
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;    // {cmd[1:0], buf[1:0], tag[3:0]} once SHIFT completes
  logic       r_act_vld;  // one-cycle strobe: a frame finished at STOP last cycle
  logic       r_act_err;  // that frame failed stop/parity/buffer-range checks

  logic [1:0] w_cmd;
  logic [1:0] w_buf;
  logic [3:0] w_tag;
  logic       w_buf_bad;
  logic       w_frame_err;

  assign w_cmd = r_shift[7:6];
  assign w_buf = r_shift[5:4];
  assign w_tag = r_shift[3:0];

  // Widen by one bit so the range check stays meaningful for NBUF=4.
  assign w_buf_bad = ({1'b0, w_buf} >= 3'(NBUF));

`ifdef TURF_CMD_PARITY_EN
  logic r_par;
  // Odd parity: payload plus parity bit must contain an odd number of ones.
  assign w_frame_err = w_bit | w_buf_bad | ~(^{r_shift, r_par});
`else
  assign w_frame_err = w_bit | w_buf_bad;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_shift   <= 8'd0;
      r_act_vld <= 1'b0;
      r_act_err <= 1'b0;
`ifdef TURF_CMD_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_act_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_bit) begin
            r_state <= S_SHIFT;
            r_cnt   <= 3'd0;
          end
        end
        S_SHIFT: begin
          r_shift <= {r_shift[6:0], w_bit};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
`ifdef TURF_CMD_PARITY_EN
            r_state <= S_PARITY;
`else
            r_state <= S_STOP;
`endif
          end
        end
`ifdef TURF_CMD_PARITY_EN
        S_PARITY: begin
          r_par   <= w_bit;
          r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Decision point: w_bit is the stop bit. The payload stays in
          // r_shift through the action cycle because IDLE never shifts.
          r_act_vld <= 1'b1;
          r_act_err <= w_frame_err;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Command actions (registered one cycle after STOP)
  // ------------------------------------------------------------------
  logic [NBUF-1:0]  r_pend;
  logic [NBUF-1:0]  r_clear;
  logic             r_rst_req;
  logic [3:0]       r_tag;
  logic             r_evt;
  logic [ERR_W-1:0] r_err;

  logic [NBUF-1:0]  w_buf_oh;
  logic [NBUF-1:0]  w_pend_live;
  logic [NBUF-1:0]  w_pend_nxt;
  logic [NBUF-1:0]  w_clear_nxt;
  logic             w_rst_nxt;
  logic             w_evt_nxt;
  logic [3:0]       w_tag_nxt;
  logic             w_err_inc;

  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      w_buf_oh[b] = (w_buf == 2'(b));
    end
  end

  // A done_i in the same cycle releases the buffer, so a digitize landing
  // then is a fresh request rather than an overflow.
  assign w_pend_live = r_pend & ~done_i;

  always_comb begin
    w_pend_nxt  = w_pend_live;
    w_clear_nxt = '0;
    w_rst_nxt   = 1'b0;
    w_evt_nxt   = 1'b0;
    w_tag_nxt   = r_tag;
    w_err_inc   = 1'b0;
    if (r_act_vld) begin
      if (r_act_err) begin
        // All error causes in one frame collapse into one increment.
        w_err_inc = 1'b1;
      end else begin
        case (w_cmd)
          CMD_DIG: begin
            if ((w_pend_live & w_buf_oh) != '0) begin
              w_err_inc = 1'b1;
            end else begin
              w_pend_nxt = w_pend_live | w_buf_oh;
              w_evt_nxt  = 1'b1;
              w_tag_nxt  = w_tag;
            end
          end
          CMD_CLR: begin
            w_pend_nxt  = w_pend_live & ~w_buf_oh;
            w_clear_nxt = w_buf_oh;
          end
          CMD_RST: begin
            w_pend_nxt = '0;
            w_rst_nxt  = 1'b1;
          end
          CMD_NOP: begin
            w_pend_nxt = w_pend_live;
          end
          default: begin
            w_pend_nxt = w_pend_live;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend    <= '0;
      r_clear   <= '0;
      r_rst_req <= 1'b0;
      r_tag     <= 4'd0;
      r_evt     <= 1'b0;
      r_err     <= '0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_clear   <= w_clear_nxt;
      r_rst_req <= w_rst_nxt;
      r_tag     <= w_tag_nxt;
      r_evt     <= w_evt_nxt;
      if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign digitize_o  = r_pend;
  assign clear_o     = r_clear;
  assign rst_req_o   = r_rst_req;
  assign evt_tag_o   = r_tag;
  assign evt_valid_o = r_evt;
  assign err_cnt_o   = r_err;

endmodule
